// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Multiply takes one product cycle; divide uses a restoring shift-subtract, one bit per cycle.
//
// state   | meaning
// S_IDLE  | waiting for a request, in_ready high
// S_MUL   | register the 2*XLEN product
// S_DINIT | load operand magnitudes and the iteration counter
// S_DIV   | one quotient bit per cycle
// S_FIX   | sign correction / high-low select into result
// S_SPEC  | divide-by-zero or signed overflow result
// S_DONE  | result valid, held until out_ready
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int DIV_RADIX2 = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DINIT, S_DIV, S_FIX, S_SPEC, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q, dvs_q, result_q;
    logic [2*XLEN-1:0] prod_q;
    logic [CW-1:0]     cnt_q;

    logic              accept, spec, div_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b;
    logic [XLEN-1:0]   a_mag, b_mag, q_fix, r_fix, fix_res, spec_res;
    logic [XLEN:0]     trial;

    // Special divide cases are recognised on the raw request operands.
    assign spec   = op[2] && ((b == '0) || (!op[0] && (a == MIN_INT) && (b == '1)));
    assign accept = (state == S_IDLE) && in_valid && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = spec ? S_SPEC : (op[2] ? S_DINIT : S_MUL);
            end
            S_MUL:   state_nx = S_FIX;
            S_DINIT: state_nx = S_DIV;
            S_DIV:   if (cnt_q == '0) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_SPEC:  state_nx = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    assign result = result_q;

    // Sign extension to 2*XLEN makes a plain unsigned multiply exact for all four variants.
    assign mul_a = {{XLEN{((op_q == 3'd1) || (op_q == 3'd2)) && a_q[XLEN-1]}}, a_q};
    assign mul_b = {{XLEN{(op_q == 3'd1) && b_q[XLEN-1]}}, b_q};

    assign div_sgn = !op_q[0];
    // MIN_INT negates to itself, which is still the correct unsigned magnitude.
    assign a_mag   = (div_sgn && a_q[XLEN-1]) ? -a_q : a_q;
    assign b_mag   = (div_sgn && b_q[XLEN-1]) ? -b_q : b_q;
    assign trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    assign q_fix = (div_sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    assign r_fix = (div_sgn && a_q[XLEN-1]) ? -rem_q : rem_q;

    always_comb begin
        fix_res = '0;
        if (op_q[2])                fix_res = op_q[1] ? r_fix : q_fix;
        else if (op_q[1:0] == 2'b00) fix_res = prod_q[XLEN-1:0];
        else                        fix_res = prod_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        spec_res = '0;
        if (b_q == '0) spec_res = op_q[1] ? a_q : '1;
        else           spec_res = op_q[1] ? '0 : a_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            case (state)
                S_MUL: prod_q <= mul_a * mul_b;
                S_DINIT: begin
                    quo_q <= a_mag;
                    rem_q <= '0;
                    dvs_q <= b_mag;
                    cnt_q <= CW'(XLEN / DIV_RADIX2 - 1);
                end
                S_DIV: begin
                    if (!trial[XLEN]) begin
                        rem_q <= trial[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_FIX:   result_q <= fix_res;
                S_SPEC:  result_q <= spec_res;
                default: ;
            endcase
        end
    end
endmodule
